// File: rtl/cgrng_rr_dispatcher_pkg.sv
// ---------------------------------------------------------------------------
// cgrng_pkg
//   Shared types and helpers for the complex Gaussian RNG dispatcher.
//   - cplx_t     : one complex sample (re/im) at the default sample width
//   - state_t    : dispatcher FSM states
//   - ST_IDLE / ST_SERVE : the same states as plain logic constants, used by
//                  the RTL state register
//   - idx_to_onehot16 : index to one-hot decode, supports up to 16 consumers
// ---------------------------------------------------------------------------
package cgrng_pkg;

  localparam int CPLX_W = 16;

  typedef struct packed {
    logic signed [CPLX_W-1:0] re;
    logic signed [CPLX_W-1:0] im;
  } cplx_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SERVE = 1'b1;

  // Decode a consumer index into a 16-bit one-hot vector.
  function automatic logic [15:0] idx_to_onehot16(input logic [3:0] idx);
    logic [15:0] oh;
    oh = 16'h0001 << idx;
    return oh;
  endfunction

endpackage

// File: rtl/cgrng_rr_dispatcher_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational rotated-priority picker. Searches rr_ptr_i+1 .. rr_ptr_i+N
//   (mod N) for the first set request. When excl_en_i is set, the consumer at
//   excl_ptr_i is skipped unless it is the only requester.
// Ports
//   req_i       in  N   request vector
//   rr_ptr_i    in  IW  last granted index (search starts one past it)
//   excl_en_i   in  1   enable exclusion of excl_ptr_i
//   excl_ptr_i  in  IW  index to exclude when others are requesting
//   any_o       out 1   at least one request is set
//   idx_o       out IW  picked index (0 when any_o is low)
// ---------------------------------------------------------------------------
module rr_pick
  import cgrng_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] rr_ptr_i,
  input  logic          excl_en_i,
  input  logic [IW-1:0] excl_ptr_i,
  output logic          any_o,
  output logic [IW-1:0] idx_o
);

  logic [N-1:0] excl_mask_s;
  logic [N-1:0] masked_s;
  logic [N-1:0] pool_s;

  // Build the candidate pool: drop the excluded index only when someone else wants a turn
  always_comb begin
    excl_mask_s = {N{1'b0}};
    if (excl_en_i) begin
      excl_mask_s = {{(N-1){1'b0}}, 1'b1} << excl_ptr_i;
    end else begin
      excl_mask_s = {N{1'b0}};
    end
    masked_s = req_i & ~excl_mask_s;
    if (masked_s != {N{1'b0}}) begin
      pool_s = masked_s;
    end else begin
      pool_s = req_i;
    end
    any_o = |req_i;
  end

  // Rotated search: first set bit starting one past the round-robin pointer
  always_comb begin
    int   c;
    logic found;
    c     = 0;
    found = 1'b0;
    idx_o = {IW{1'b0}};
    for (int i = 1; i <= N; i++) begin
      c = (int'(rr_ptr_i) + i) % N;
      if (!found && pool_s[c]) begin
        idx_o = IW'(c);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/cgrng_rr_dispatcher.sv
// ---------------------------------------------------------------------------
// cgrng_rr_dispatcher
//   Shares one complex Gaussian sample stream between N consumers using
//   round-robin arbitration with at most BURST samples per grant, through a
//   single registered output stage. Every accepted sample is delivered to
//   exactly one consumer.
// Parameters
//   N (2..16) consumers, W sample width of re/im, BURST (1..256) grant length
// Ports
//   clk, reset_n            clock (posedge), async active-low reset
//   gen_valid/gen_ready     generator handshake (gen_ready is combinational)
//   gen_re/gen_im           generator sample
//   req                     per-consumer level request
//   out_valid               one-hot offer to consumer out_gid (registered)
//   out_ready               per-consumer accept; only out_ready[out_gid] matters
//   out_re/out_im/out_gid   offered sample and its destination (registered)
//   busy                    high while a sample is held in the stage
//   stat_cnt[N]             per-consumer delivered count, 32-bit wrapping
//                           (present only with CGRNG_DISPATCH_STATS_EN defined)
// Configuration macro: CGRNG_DISPATCH_STATS_EN
// ---------------------------------------------------------------------------
module cgrng_rr_dispatcher
  import cgrng_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = 16,
  parameter int BURST = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  gen_valid,
  output logic                  gen_ready,
  input  logic signed [W-1:0]   gen_re,
  input  logic signed [W-1:0]   gen_im,
  input  logic [N-1:0]          req,
  output logic [N-1:0]          out_valid,
  input  logic [N-1:0]          out_ready,
  output logic signed [W-1:0]   out_re,
  output logic signed [W-1:0]   out_im,
  output logic [$clog2(N)-1:0]  out_gid,
  output logic                  busy
`ifdef CGRNG_DISPATCH_STATS_EN
  ,
  output logic [31:0]           stat_cnt [N]
`endif
);

  localparam int IW  = $clog2(N);
  localparam int BCW = $clog2(BURST) + 1;

  logic [0:0]           state_q,     state_d;
  logic [N-1:0]         out_valid_q, out_valid_d;
  logic signed [W-1:0]  out_re_q,    out_re_d;
  logic signed [W-1:0]  out_im_q,    out_im_d;
  logic [IW-1:0]        out_gid_q,   out_gid_d;
  logic [IW-1:0]        rr_ptr_q,    rr_ptr_d;
  logic [BCW-1:0]       burst_cnt_q, burst_cnt_d;

  logic                 drain_s;
  logic                 cont_s;
  logic                 excl_en_s;
  logic                 pick_any_s;
  logic [IW-1:0]        pick_idx_s;
  logic                 next_ok_s;
  logic [IW-1:0]        next_gid_s;
  logic [N-1:0]         next_oh_s;
  logic                 gen_ready_s;

  // While serving, the current holder goes to the back of the queue on a re-pick.
  assign excl_en_s = (state_q == ST_SERVE);

  rr_pick #(.N(N)) u_pick (
    .req_i      (req),
    .rr_ptr_i   (rr_ptr_q),
    .excl_en_i  (excl_en_s),
    .excl_ptr_i (out_gid_q),
    .any_o      (pick_any_s),
    .idx_o      (pick_idx_s)
  );

  // Drain and burst-continuation conditions for the currently held sample
  always_comb begin
    drain_s = out_valid_q[out_gid_q] & out_ready[out_gid_q];
    if (req[out_gid_q] && ((int'(burst_cnt_q) + 1) < BURST)) begin
      cont_s = 1'b1;
    end else begin
      cont_s = 1'b0;
    end
  end

  // Choose the target for the next loaded sample: stay in the burst or re-pick
  always_comb begin
    next_ok_s  = pick_any_s;
    next_gid_s = pick_idx_s;
    if ((state_q == ST_SERVE) && cont_s) begin
      next_ok_s  = 1'b1;
      next_gid_s = out_gid_q;
    end else begin
      next_ok_s  = pick_any_s;
      next_gid_s = pick_idx_s;
    end
    next_oh_s = N'(idx_to_onehot16(4'(next_gid_s)));
  end

  // Dispatcher FSM: load, hold until drained, reload on the drain cycle
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    out_gid_d   = out_gid_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    gen_ready_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        gen_ready_s = pick_any_s;
        if (gen_valid && pick_any_s) begin
          out_re_d    = gen_re;
          out_im_d    = gen_im;
          out_gid_d   = next_gid_s;
          out_valid_d = next_oh_s;
          rr_ptr_d    = next_gid_s;
          burst_cnt_d = {BCW{1'b0}};
          state_d     = ST_SERVE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVE: begin
        if (drain_s) begin
          // Taking a new beat only on drain keeps the offered sample stable.
          gen_ready_s = next_ok_s;
          if (gen_valid && next_ok_s) begin
            out_re_d    = gen_re;
            out_im_d    = gen_im;
            out_gid_d   = next_gid_s;
            out_valid_d = next_oh_s;
            if (cont_s) begin
              burst_cnt_d = burst_cnt_q + {{(BCW-1){1'b0}}, 1'b1};
            end else begin
              burst_cnt_d = {BCW{1'b0}};
              rr_ptr_d    = next_gid_s;
            end
          end else begin
            out_valid_d = {N{1'b0}};
            burst_cnt_d = {BCW{1'b0}};
            state_d     = ST_IDLE;
          end
        end else begin
          gen_ready_s = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = {N{1'b0}};
        burst_cnt_d = {BCW{1'b0}};
      end
    endcase
  end

  // State and output stage registers; reset discards any held sample
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= {N{1'b0}};
      out_re_q    <= {W{1'b0}};
      out_im_q    <= {W{1'b0}};
      out_gid_q   <= {IW{1'b0}};
      rr_ptr_q    <= IW'(N - 1);
      burst_cnt_q <= {BCW{1'b0}};
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      out_gid_q   <= out_gid_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign gen_ready = gen_ready_s;
  assign out_valid = out_valid_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign out_gid   = out_gid_q;
  assign busy      = (state_q == ST_SERVE);

`ifdef CGRNG_DISPATCH_STATS_EN
  logic [31:0] stat_q [N];

  // Per-consumer delivered-sample counters, wrapping at 2^32
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        stat_q[i] <= 32'd0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (drain_s && (out_gid_q == IW'(i))) begin
          stat_q[i] <= stat_q[i] + 32'd1;
        end
      end
    end
  end

  assign stat_cnt = stat_q;
`endif

endmodule

// File: tb/tb_cgrng_rr_dispatcher.sv
module tb_cgrng_rr_dispatcher;

  localparam int N     = 4;
  localparam int W     = 16;
  localparam int BURST = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          gen_valid;
  logic          gen_ready;
  logic [W-1:0]  gen_re, gen_im;
  logic [N-1:0]  req;
  logic [N-1:0]  out_valid;
  logic [N-1:0]  out_ready;
  logic [W-1:0]  out_re, out_im;
  logic [1:0]    out_gid;
  logic          busy;
`ifdef CGRNG_DISPATCH_STATS_EN
  logic [31:0]   stat_cnt [N];
`endif

  always #5 clk = ~clk;

  cgrng_rr_dispatcher #(.N(N), .W(W), .BURST(BURST)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .gen_valid (gen_valid),
    .gen_ready (gen_ready),
    .gen_re    (gen_re),
    .gen_im    (gen_im),
    .req       (req),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_gid   (out_gid),
    .busy      (busy)
`ifdef CGRNG_DISPATCH_STATS_EN
    ,
    .stat_cnt  (stat_cnt)
`endif
  );

  typedef struct {
    int           gid;
    logic [W-1:0] re;
    logic [W-1:0] im;
  } exp_t;

  exp_t sb_q[$];
  int   gid_plan[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   seq     = 0;
  int   stalls;
  int   w;
  logic [W-1:0] a_re, a_im;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: every drain must match the oldest pending expected sample
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && ((out_valid & out_ready) != 4'b0000)) begin
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_delivery: gid %0d re %0h delivered, expected nothing pending",
                 out_gid, out_re);
      end else begin
        e = sb_q.pop_front();
        chk("deliver_valid", 64'(out_valid), 64'(4'b0001 << e.gid));
        chk("deliver_gid",   64'(out_gid),   64'(e.gid));
        chk("deliver_re",    64'(out_re),    64'(e.re));
        chk("deliver_im",    64'(out_im),    64'(e.im));
      end
    end
  end

  // Offer one fresh beat and wait for it to be accepted; records expected target
  task automatic accept_one(input int exp_gid, output int waited);
    exp_t e;
    waited = 0;
    seq++;
    gen_re    = 16'h1000 + 16'(seq);
    gen_im    = 16'hF000 - 16'(seq * 7);
    gen_valid = 1'b1;
    @(negedge clk);
    while (!gen_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (gen_ready) begin
      e.gid = exp_gid;
      e.re  = gen_re;
      e.im  = gen_im;
      sb_q.push_back(e);
    end else begin
      n_total++;
      $display("FAIL accept_timeout: gen_ready 0, expected 1 (target gid %0d)", exp_gid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beats(input int n, output int stall_cycles);
    int wt;
    stall_cycles = 0;
    for (int k = 0; k < n; k++) begin
      accept_one(gid_plan.pop_front(), wt);
      stall_cycles += wt;
    end
    gen_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (((out_valid != 4'b0000) || (sb_q.size() != 0)) && c < 60) begin
      @(negedge clk);
      c++;
    end
    chk("drain_complete", 64'(sb_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    gen_valid = 1'b0;
    req       = 4'b0000;
    out_ready = 4'b0000;
    sb_q.delete();
    gid_plan.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; gen_valid = 1'b0; gen_re = 16'h0000; gen_im = 16'h0000;
    req = 4'b0000; out_ready = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_re",    64'(out_re),    64'd0);
    chk("reset_out_im",    64'(out_im),    64'd0);
    chk("reset_out_gid",   64'(out_gid),   64'd0);
    chk("reset_busy",      64'(busy),      64'd0);
    chk("reset_gen_ready", 64'(gen_ready), 64'd0);
    reset_n = 1'b1;

    // Single requester: one sample per cycle, never stalls
    req = 4'b0001; out_ready = 4'b1111;
    for (int k = 0; k < 6; k++) gid_plan.push_back(0);
    drive_beats(6, stalls);
    chk("t1_no_stall", 64'(stalls), 64'd0);
    wait_idle();

    // No gen_valid: stay idle, grant not consumed; then round-robin bursts of 4
    do_reset();
    req = 4'b1111; out_ready = 4'b1111;
    repeat (3) begin
      @(negedge clk);
      chk("t2_idle_busy",  64'(busy),      64'd0);
      chk("t2_idle_valid", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    for (int g = 0; g < 4; g++) for (int k = 0; k < 4; k++) gid_plan.push_back(g);
    gid_plan.push_back(0);
    drive_beats(17, stalls);
    chk("t2_no_stall", 64'(stalls), 64'd0);
    wait_idle();

    // Backpressure on the granted consumer; other ready bits must be ignored
    req = 4'b0100; out_ready = 4'b0000;
    accept_one(2, w);
    a_re = gen_re; a_im = gen_im;
    out_ready = 4'b1011;
    repeat (5) begin
      @(negedge clk);
      chk("t3_hold_valid",     64'(out_valid), 64'(4'b0100));
      chk("t3_hold_gid",       64'(out_gid),   64'd2);
      chk("t3_hold_re",        64'(out_re),    64'(a_re));
      chk("t3_hold_im",        64'(out_im),    64'(a_im));
      chk("t3_gen_ready_low",  64'(gen_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 4'b1111;
    gid_plan.push_back(2);
    drive_beats(1, stalls);
    chk("t3_reload_on_drain", 64'(stalls), 64'd0);
    wait_idle();

    // Request drop while offered: sample still delivered, then next requester
    req = 4'b0010; out_ready = 4'b0000;
    accept_one(1, w);
    gen_valid = 1'b0;
    a_re = gen_re;
    req = 4'b1000;
    repeat (3) begin
      @(negedge clk);
      chk("t4_hold_valid", 64'(out_valid), 64'(4'b0010));
      chk("t4_hold_re",    64'(out_re),    64'(a_re));
      chk("t4_gen_ready",  64'(gen_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 4'b1111;
    gid_plan.push_back(3);
    drive_beats(1, stalls);
    chk("t4_switch_no_stall", 64'(stalls), 64'd0);
    wait_idle();

    // Async reset mid-burst discards the held sample; next grant goes to 0
    req = 4'b0010; out_ready = 4'b0000;
    accept_one(1, w);
    gen_valid = 1'b0;
    @(negedge clk);
    chk("t5_pre_valid", 64'(out_valid), 64'(4'b0010));
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_async_valid", 64'(out_valid), 64'd0);
    chk("t5_async_busy",  64'(busy),      64'd0);
    chk("t5_async_re",    64'(out_re),    64'd0);
    sb_q.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    req = 4'b1111; out_ready = 4'b1111;
    gid_plan.push_back(0);
    gid_plan.push_back(0);
    drive_beats(2, stalls);
    wait_idle();

`ifdef CGRNG_DISPATCH_STATS_EN
    do_reset();
    for (int i = 0; i < N; i++) chk("stat_reset", 64'(stat_cnt[i]), 64'd0);
    req = 4'b0001; out_ready = 4'b1111;
    for (int k = 0; k < 10; k++) gid_plan.push_back(0);
    drive_beats(10, stalls);
    wait_idle();
    req = 4'b0100;
    for (int k = 0; k < 3; k++) gid_plan.push_back(2);
    drive_beats(3, stalls);
    wait_idle();
    chk("stat_cnt0", 64'(stat_cnt[0]), 64'd10);
    chk("stat_cnt1", 64'(stat_cnt[1]), 64'd0);
    chk("stat_cnt2", 64'(stat_cnt[2]), 64'd3);
    chk("stat_cnt3", 64'(stat_cnt[3]), 64'd0);
`endif

    chk("sb_empty_end", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
